// File: rtl/cache_control_pkg.sv
// lc3b_types: shared cache controller state encoding and datapath mux selects.
package lc3b_types;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WT_WRITE} cache_state;
  localparam logic PMEM_ADDR_CPU = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;
  localparam logic DATA_IN_CPU = 1'b0;
  localparam logic DATA_IN_PMEM = 1'b1;
endpackage

// File: rtl/cache_control_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (!reset_n) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/cache_control.sv
// cache_control: L1 cache sequencing FSM (compare, writeback, allocate,
// write-through) with saturating hit/miss counters.
module cache_control
  import lc3b_types::*;
#(
  parameter int WAYS = 2,
  parameter int WRITE_BACK = 1,
  parameter int CNT_W = 16,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic [WAY_W-1:0] hit_way,
  input  logic [WAY_W-1:0] lru_way,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic [WAY_W-1:0] way_sel,
  output logic             load_data,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_dirty,
  output logic             load_lru,
  output logic             dirty_in,
  output logic             data_in_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam bit WB = WRITE_BACK != 0;
  cache_state state, nxt;
  logic recmp;
  logic wt_wr;
  logic victim_wb;
  assign wt_wr = !WB && mem_write;
  assign victim_wb = WB && victim_valid && victim_dirty;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      recmp <= 1'b0;
    end else begin
      state <= nxt;
      recmp <= state == ALLOCATE && pmem_resp;
    end
  always_comb begin
    nxt = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_addr_sel = PMEM_ADDR_CPU;
    way_sel = '0;
    load_data = 1'b0;
    load_tag = 1'b0;
    load_valid = 1'b0;
    load_dirty = 1'b0;
    load_lru = 1'b0;
    dirty_in = 1'b0;
    data_in_sel = DATA_IN_CPU;
    case (state)
      IDLE: nxt = (mem_read || mem_write) ? COMPARE : IDLE;
      COMPARE:
        if (hit) begin
          way_sel = hit_way;
          load_lru = 1'b1;
          load_data = mem_write;
          load_dirty = mem_write && WB;
          dirty_in = mem_write && WB;
          mem_resp = !wt_wr;
          nxt = wt_wr ? WT_WRITE : IDLE;
        end else nxt = wt_wr ? WT_WRITE : victim_wb ? WRITEBACK : ALLOCATE;
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_addr_sel = PMEM_ADDR_VICTIM;
        way_sel = lru_way;
        nxt = pmem_resp ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel = lru_way;
        load_data = pmem_resp;
        load_tag = pmem_resp;
        load_valid = pmem_resp;
        load_dirty = pmem_resp;
        data_in_sel = pmem_resp ? DATA_IN_PMEM : DATA_IN_CPU;
        nxt = pmem_resp ? COMPARE : ALLOCATE;
      end
      WT_WRITE: begin
        pmem_write = 1'b1;
        mem_resp = pmem_resp;
        nxt = pmem_resp ? IDLE : WT_WRITE;
      end
      default: nxt = IDLE;
    endcase
    // a cycle with reset low must neither complete the request nor touch the arrays
    if (!reset_n) begin
      mem_resp = 1'b0;
      load_data = 1'b0;
      load_tag = 1'b0;
      load_valid = 1'b0;
      load_dirty = 1'b0;
      load_lru = 1'b0;
    end
  end
  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .inc(state == COMPARE && !recmp && hit),
    .count(hit_count)
  );
  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .inc(state == COMPARE && !recmp && !hit),
    .count(miss_count)
  );
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: randomized request-level checks of a 4-way write-back
// controller (4-bit counters) and a 2-way write-through controller.
module tb_cache_control;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic rd_wb = 1'b0, wr_wb = 1'b0, rd_wt = 1'b0, wr_wt = 1'b0;
  logic hit = 1'b0, victim_valid = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;
  logic [1:0] hw = '0, lw = '0;
  logic wb_resp, wb_pr, wb_pw, wb_as, wb_ld, wb_lt, wb_lv, wb_ldy, wb_ll, wb_di, wb_dis;
  logic wt_resp, wt_pr, wt_pw, wt_as, wt_ld, wt_lt, wt_lv, wt_ldy, wt_ll, wt_di, wt_dis;
  logic [1:0] wb_way;
  logic [0:0] wt_way;
  logic [3:0] wb_hc, wb_mc;
  logic [15:0] wt_hc, wt_mc;
  cache_control #(.WAYS(4), .WRITE_BACK(1), .CNT_W(4)) u_wb (
    .clk(clk), .reset_n(reset_n), .mem_read(rd_wb), .mem_write(wr_wb), .mem_resp(wb_resp),
    .hit(hit), .hit_way(hw), .lru_way(lw), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .pmem_resp(pmem_resp), .pmem_read(wb_pr), .pmem_write(wb_pw), .pmem_addr_sel(wb_as),
    .way_sel(wb_way), .load_data(wb_ld), .load_tag(wb_lt), .load_valid(wb_lv), .load_dirty(wb_ldy),
    .load_lru(wb_ll), .dirty_in(wb_di), .data_in_sel(wb_dis), .hit_count(wb_hc), .miss_count(wb_mc)
  );
  cache_control #(.WAYS(2), .WRITE_BACK(0), .CNT_W(16)) u_wt (
    .clk(clk), .reset_n(reset_n), .mem_read(rd_wt), .mem_write(wr_wt), .mem_resp(wt_resp),
    .hit(hit), .hit_way(hw[0]), .lru_way(lw[0]), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .pmem_resp(pmem_resp), .pmem_read(wt_pr), .pmem_write(wt_pw), .pmem_addr_sel(wt_as),
    .way_sel(wt_way), .load_data(wt_ld), .load_tag(wt_lt), .load_valid(wt_lv), .load_dirty(wt_ldy),
    .load_lru(wt_ll), .dirty_in(wt_di), .data_in_sel(wt_dis), .hit_count(wt_hc), .miss_count(wt_mc)
  );
  bit tgt = 1'b0;
  logic s_resp, s_pr, s_pw, s_as, s_ld, s_lt, s_lv, s_ldy, s_ll, s_di, s_dis;
  logic [1:0] s_way;
  logic [15:0] s_hc, s_mc;
  assign {s_resp, s_pr, s_pw, s_as, s_ld, s_lt, s_lv, s_ldy, s_ll, s_di, s_dis} = tgt ?
    {wt_resp, wt_pr, wt_pw, wt_as, wt_ld, wt_lt, wt_lv, wt_ldy, wt_ll, wt_di, wt_dis} :
    {wb_resp, wb_pr, wb_pw, wb_as, wb_ld, wb_lt, wb_lv, wb_ldy, wb_ll, wb_di, wb_dis};
  assign s_way = tgt ? {1'b0, wt_way} : wb_way;
  assign s_hc = tgt ? wt_hc : {12'b0, wb_hc};
  assign s_mc = tgt ? wt_mc : {12'b0, wb_mc};
  int tests = 0, fails = 0;
  int exp_h[2], exp_m[2];
  int cmax[2] = '{15, 65535};
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    {rd_wb, wr_wb, rd_wt, wr_wt, hit, pmem_resp} = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_h = '{0, 0};
    exp_m = '{0, 0};
  endtask
  // One CPU request on controller w (0 = write-back, 1 = write-through), with
  // a pmem that answers lat cycles after each request first appears.
  task automatic run_req(input bit w, input bit wr, input bit h, input bit vv, input bit vd,
                         input int lat, input logic [1:0] hwv, input logic [1:0] lwv);
    int run = 0, rc = -1, erc, bad_way = 0;
    int wb_n = 0, wt_n = 0, al_n = 0, cw_n = 0, ds_n = 0, dc_n = 0;
    int e_wb, e_wt, e_al, e_cw, e_ds;
    logic [1:0] ehw, elw;
    bit wt_wr, dirty;
    ehw = w ? {1'b0, hwv[0]} : hwv;
    elw = w ? {1'b0, lwv[0]} : lwv;
    wt_wr = w && wr;
    dirty = !w && vv && vd;
    erc = wt_wr ? lat + 2 : h ? 1 : dirty ? 2 * lat + 4 : lat + 3;
    e_wb = int'(!h && dirty);
    e_wt = int'(wt_wr);
    e_al = int'(!h && !wt_wr);
    e_cw = int'(wr && (h || !w));
    e_ds = int'(wr && !w);
    @(negedge clk);
    tgt = w;
    hw = hwv;
    lw = lwv;
    victim_valid = vv;
    victim_dirty = vd;
    {rd_wb, wr_wb, rd_wt, wr_wt} = '0;
    if (w) begin wr_wt = wr; rd_wt = wr ? 1'($urandom % 2) : 1'b1; end
    else begin wr_wb = wr; rd_wb = wr ? 1'($urandom % 2) : 1'b1; end
    for (int c = 0; c < 100 && rc < 0; c++) begin
      if (c > 0) @(negedge clk);
      hit = (c <= 1) ? h : 1'b1;
      pmem_resp = (run == lat);
      #1;
      if (s_resp) rc = c;
      if (s_pw && pmem_resp) begin if (s_as) wb_n++; else wt_n++; end
      if (s_lt && s_lv) al_n++;
      if (s_ld && !s_dis) cw_n++;
      if (s_ldy && s_di) ds_n++;
      if (s_ldy && !s_di && s_ld && s_dis) dc_n++;
      if ((s_pr || (s_pw && s_as)) && s_way != elw) bad_way++;
      if (s_ll && s_way != ehw) bad_way++;
      run = (s_pr || s_pw) ? (pmem_resp ? 0 : run + 1) : 0;
    end
    if (h) exp_h[w] = exp_h[w] < cmax[w] ? exp_h[w] + 1 : exp_h[w];
    else exp_m[w] = exp_m[w] < cmax[w] ? exp_m[w] + 1 : exp_m[w];
    tests++;
    if (rc !== erc) begin
      fails++;
      $display("FAIL resp_cycle w=%0d wr=%0d h=%0d lat=%0d got %0d want %0d", w, wr, h, lat, rc, erc);
    end
    tests++;
    if ({wb_n, wt_n, al_n, cw_n, ds_n, dc_n} !== {e_wb, e_wt, e_al, e_cw, e_ds, e_al}) begin
      fails++;
      $display("FAIL actions w=%0d wr=%0d h=%0d got wb%0d wt%0d al%0d cw%0d ds%0d dc%0d want wb%0d wt%0d al%0d cw%0d ds%0d dc%0d",
               w, wr, h, wb_n, wt_n, al_n, cw_n, ds_n, dc_n, e_wb, e_wt, e_al, e_cw, e_ds, e_al);
    end
    tests++;
    if (bad_way != 0) begin
      fails++;
      $display("FAIL way_sel w=%0d got %0d bad cycles want 0", w, bad_way);
    end
    @(posedge clk);
    #1;
    tests++;
    if (s_hc !== 16'(exp_h[w]) || s_mc !== 16'(exp_m[w])) begin
      fails++;
      $display("FAIL counters w=%0d got hit=%0d miss=%0d want hit=%0d miss=%0d", w, s_hc, s_mc, exp_h[w], exp_m[w]);
    end
  endtask
  task automatic go_idle();
    @(negedge clk);
    {rd_wb, wr_wb, rd_wt, wr_wt, pmem_resp} = '0;
    #1;
    tests++;
    if (s_resp || s_pr || s_pw) begin
      fails++;
      $display("FAIL idle_quiet got resp=%0d pr=%0d pw=%0d want 0", s_resp, s_pr, s_pw);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({wb_resp, wb_pr, wb_pw, wb_as, wb_ld, wb_lt, wb_lv, wb_ldy, wb_ll, wb_di, wb_dis, wb_way, wb_hc, wb_mc,
         wt_resp, wt_pr, wt_pw, wt_as, wt_ld, wt_lt, wt_lv, wt_ldy, wt_ll, wt_di, wt_dis, wt_way, wt_hc, wt_mc} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got nonzero output want all 0");
    end
    do_reset();
  endtask
  task automatic test_read_hit_way4();
    do_reset();
    run_req(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 2'd2, 2'd0);
    go_idle();
  endtask
  task automatic test_dirty_miss();
    do_reset();
    run_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2'd1, 2'd1);
    go_idle();
  endtask
  task automatic test_write_through();
    do_reset();
    run_req(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 2'd0, 2'd1);
    run_req(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 2'd1, 2'd0);
    run_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 2'd0, 2'd1);
    go_idle();
  endtask
  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) run_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2'(i), 2'd0);
    go_idle();
    tests++;
    if (wb_hc !== 4'd15) begin
      fails++;
      $display("FAIL hit_saturate got %0d want 15", wb_hc);
    end
  endtask
  task automatic test_reset_mid_alloc();
    bit seen = 1'b0;
    do_reset();
    @(negedge clk);
    tgt = 1'b0;
    rd_wb = 1'b1;
    hit = 1'b0;
    victim_valid = 1'b0;
    pmem_resp = 1'b0;
    lw = 2'd3;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = s_pr;
    end
    tests++;
    if (!seen || s_mc !== 16'd1) begin
      fails++;
      $display("FAIL alloc_entry got pmem_read=%0d miss=%0d want 1 1", seen, s_mc);
    end
    reset_n = 1'b0;
    pmem_resp = 1'b1;
    #1;
    tests++;
    if (s_lt || s_lv || s_ld || s_ldy || s_resp) begin
      fails++;
      $display("FAIL reset_cycle_loads got tag=%0d data=%0d resp=%0d want 0", s_lt, s_ld, s_resp);
    end
    @(negedge clk);
    #1;
    tests++;
    if (s_pr || s_resp || s_hc !== 16'd0 || s_mc !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_alloc got pr=%0d resp=%0d hit=%0d miss=%0d want 0", s_pr, s_resp, s_hc, s_mc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd_wb = 1'b0;
    pmem_resp = 1'b0;
    exp_h = '{0, 0};
    exp_m = '{0, 0};
    go_idle();
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++)
      run_req(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
              int'($urandom_range(1, 4)), 2'($urandom % 4), 2'($urandom % 4));
    go_idle();
  endtask
  initial begin
    test_reset();
    test_read_hit_way4();
    test_dirty_miss();
    test_write_through();
    test_saturate();
    test_reset_mid_alloc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
